// File: rtl/pio_display_arbiter_if.sv
// Bundle of the requester handshake and display-side outputs of pio_display_arbiter.
// The master modport is the requester/board side; the slave modport is the arbiter.
interface pio_display_arbiter_if;
  logic [2:0]  req_valid;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [31:0] disp_data;
  logic [1:0]  disp_src;
  logic        disp_update;
  logic        busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, disp_data, disp_src, disp_update, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, disp_data, disp_src, disp_update, busy
  );
endinterface

// File: rtl/pio_display_arbiter.sv
// Round-robin owner of the hex display path with a minimum hold time per grant.
// Optional macro DISP_ARB_HOST_PREEMPT_EN lets the host (requester 0) cut a hold short.
module pio_display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  pio_display_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       last_reg;
  logic [31:0]      disp_data_reg;
  logic [1:0]       disp_src_reg;
  logic             disp_update_reg;

  logic [1:0]  first_idx;
  logic [1:0]  cand_idx [3];
  logic [2:0]  cand_valid;
  logic [1:0]  win_idx;
  logic        any_valid;
  logic [2:0]  ready;
  logic        xfer;
  logic [1:0]  xfer_idx;
  logic [31:0] xfer_data;

  // Search starts just after the last grant and wraps modulo 3.
  assign first_idx = (last_reg == 2'd2) ? 2'd0 : last_reg + 2'd1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cand
      logic [2:0] sum;
      assign sum            = {1'b0, first_idx} + 3'(gi);
      assign cand_idx[gi]   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_idx = 2'd0;
    if (cand_valid[0])      win_idx = cand_idx[0];
    else if (cand_valid[1]) win_idx = cand_idx[1];
    else if (cand_valid[2]) win_idx = cand_idx[2];
  end

  assign any_valid = |cand_valid;

  always_comb begin
    ready = 3'b000;
    if (!reset) begin
      if (state_reg == IDLE) begin
        if (any_valid) ready = 3'b001 << win_idx;
      end
`ifdef DISP_ARB_HOST_PREEMPT_EN
      else if (disp_src_reg != 2'd0) begin
        ready[0] = bus.req_valid[0];
      end
`endif
    end
  end

  // Outside IDLE the only possible transfer is a host preemption.
  assign xfer     = |(ready & bus.req_valid);
  assign xfer_idx = (state_reg == IDLE) ? win_idx : 2'd0;

  always_comb begin
    case (xfer_idx)
      2'd1:    xfer_data = bus.req_data[63:32];
      2'd2:    xfer_data = bus.req_data[95:64];
      default: xfer_data = bus.req_data[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      last_reg        <= 2'd2;
      disp_data_reg   <= 32'd0;
      disp_src_reg    <= 2'd3;
      disp_update_reg <= 1'b0;
    end else begin
      disp_update_reg <= 1'b0;
      if (xfer) begin
        disp_data_reg   <= xfer_data;
        disp_src_reg    <= xfer_idx;
        last_reg        <= xfer_idx;
        cnt_reg         <= '0;
        state_reg       <= HOLD;
        disp_update_reg <= 1'b1;
      end else if (state_reg == HOLD) begin
        if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.disp_data   = disp_data_reg;
  assign bus.disp_src    = disp_src_reg;
  assign bus.disp_update = disp_update_reg;
  assign bus.busy        = (state_reg == HOLD);

endmodule

// File: tb/tb_pio_display_arbiter.sv
// Directed bench for pio_display_arbiter (HOLD_CYCLES=4) with a per-cycle reference model.
// The model tracks remaining hold cycles and owner; literal checks pin the key scenarios.
module tb_pio_display_arbiter;

  localparam int H = 4;

  logic clk;
  logic reset;
  pio_display_arbiter_if bus();

  pio_display_arbiter #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  bit started = 0;
  int busy_cnt = 0;
  int upd_cyc[$];
  int upd_src[$];

  // Reference model state: remaining busy cycles, owner, shown word, last grant.
  int          m_remain = 0;
  logic [1:0]  m_owner  = 2'd3;
  logic [31:0] m_data   = 32'd0;
  int          m_last   = 2;
  logic        m_update = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [2:0] exp_ready(input logic rst, input logic [2:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (!rst) begin
      if (m_remain == 0) begin
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx = (m_last + 1 + k) % 3;
          if (v[idx] && r == 3'b000) r[idx] = 1'b1;
        end
      end
`ifdef DISP_ARB_HOST_PREEMPT_EN
      else if (m_owner != 2'd0 && v[0]) begin
        r[0] = 1'b1;
      end
`endif
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cycle++;
    if (reset) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      logic [2:0] er;
      logic [2:0] v;
      v  = bus.req_valid;
      er = exp_ready(reset, v);
      check("req_ready",   32'(bus.req_ready),   32'(er));
      check("disp_data",   bus.disp_data,        m_data);
      check("disp_src",    32'(bus.disp_src),    32'(m_owner));
      check("disp_update", 32'(bus.disp_update), 32'(m_update));
      check("busy",        32'(bus.busy),        32'(m_remain != 0));
      if (bus.busy) busy_cnt++;
      if (bus.disp_update) begin
        upd_cyc.push_back(cycle);
        upd_src.push_back(int'(bus.disp_src));
      end
      if (reset) begin
        m_remain = 0; m_owner = 2'd3; m_data = 32'd0; m_last = 2; m_update = 1'b0;
      end else begin
        m_update = 1'b0;
        if (|(er & v)) begin
          int w;
          w = er[0] ? 0 : (er[1] ? 1 : 2);
          m_owner  = 2'(w);
          m_data   = bus.req_data[32*w +: 32];
          m_last   = w;
          m_remain = H;
          m_update = 1'b1;
          $display("xfer src=%0d data=%h cycle=%0d", w, m_data, cycle);
        end else if (m_remain > 0) begin
          m_remain--;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.req_valid = 3'b000;
    bus.req_data  = 96'd0;
    repeat (3) cyc();
    reset = 1'b0;

    // Idle after reset: outputs sit at reset values.
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      check("idle_src",   32'(bus.disp_src),  32'd3);
      check("idle_data",  bus.disp_data,      32'd0);
      check("idle_busy",  32'(bus.busy),      32'd0);
      check("idle_ready", 32'(bus.req_ready), 32'd0);
    end

    // All three valid: grants 0,1,2,0 five cycles apart, 4 busy cycles each.
    bus.req_data  = {32'h33333333, 32'h22222222, 32'h11111111};
    bus.req_valid = 3'b111;
    upd_cyc.delete(); upd_src.delete();
    busy_cnt = 0;
    repeat (16) cyc();
    bus.req_valid = 3'b000;
    repeat (6) cyc();
    check("rr_count", 32'(upd_cyc.size()), 32'd4);
    if (upd_cyc.size() == 4) begin
      check("rr_src0", 32'(upd_src[0]), 32'd0);
      check("rr_src1", 32'(upd_src[1]), 32'd1);
      check("rr_src2", 32'(upd_src[2]), 32'd2);
      check("rr_src3", 32'(upd_src[3]), 32'd0);
      for (int i = 1; i < 4; i++)
        check("rr_spacing", 32'(upd_cyc[i] - upd_cyc[i-1]), 32'd5);
    end
    check("rr_busy_cycles", 32'(busy_cnt), 32'd16);

    // Single requester 2 in IDLE: zero-latency ready, data shown next cycle.
    bus.req_data[95:64] = 32'hCAFE0002;
    bus.req_valid = 3'b100;
    #1;
    check("r2_ready", 32'(bus.req_ready), 32'b100);
    cyc(); #1;
    check("r2_data",   bus.disp_data,        32'hCAFE0002);
    check("r2_src",    32'(bus.disp_src),    32'd2);
    check("r2_update", 32'(bus.disp_update), 32'd1);
    check("r2_busy",   32'(bus.busy),        32'd1);

    // Requester 1 arriving during HOLD waits for the first IDLE cycle.
    bus.req_valid = 3'b010;
    bus.req_data[63:32] = 32'h5555AAAA;
    n = 0;
    #1;
    while (!bus.req_ready[1] && n < 10) begin
      cyc(); #1;
      n++;
    end
    check("r1_wait_cycles", 32'(n), 32'd4);
    check("r1_idle_busy",   32'(bus.busy), 32'd0);
    cyc(); #1;
    bus.req_valid = 3'b000;
    check("r1_src",  32'(bus.disp_src), 32'd1);
    check("r1_data", bus.disp_data,     32'h5555AAAA);

    // Host request at hold count 2 while switches own the display.
    cyc(); cyc();
    bus.req_data[31:0] = 32'h0000B0B0;
    bus.req_valid = 3'b001;
    #1;
`ifdef DISP_ARB_HOST_PREEMPT_EN
    check("pre_ready", 32'(bus.req_ready), 32'b001);
    cyc(); #1;
    bus.req_valid = 3'b000;
    check("pre_src",    32'(bus.disp_src),    32'd0);
    check("pre_update", 32'(bus.disp_update), 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy) n++;
      cyc(); #1;
    end
    check("pre_busy_cycles", 32'(n), 32'd4);
`else
    check("nopre_ready", 32'(bus.req_ready), 32'b000);
    n = 0;
    while (!bus.req_ready[0] && n < 10) begin
      cyc(); #1;
      n++;
    end
    check("nopre_wait_cycles", 32'(n), 32'd2);
    cyc(); #1;
    bus.req_valid = 3'b000;
    check("nopre_src",  32'(bus.disp_src), 32'd0);
    check("nopre_data", bus.disp_data,     32'h0000B0B0);
`endif
    repeat (6) cyc();

    // Reset in the middle of HOLD.
    bus.req_valid = 3'b010;
    cyc();
    bus.req_valid = 3'b000;
    cyc();
    reset = 1'b1;
    bus.req_valid = 3'b100;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    cyc(); #1;
    check("rst_src",    32'(bus.disp_src),    32'd3);
    check("rst_data",   bus.disp_data,        32'd0);
    check("rst_busy",   32'(bus.busy),        32'd0);
    check("rst_update", 32'(bus.disp_update), 32'd0);
    reset = 1'b0;
    bus.req_valid = 3'b000;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
